// File: rtl/uart_trx_ctrl.sv
// uart_trx_ctrl: task/event sequencer turning start/stop pulses into registered UART RX/TX enables
// Ports:
//   ck, arst                       clock, asynchronous active-high reset
//   uartEnable                     global enable; low forces both paths idle
//   taskStart{Rx,Tx}               1-cycle start pulses
//   taskStop{Rx,Tx,Trx}            1-cycle stop pulses (Trx stops both)
//   txBusy, rxBusy                 frame in progress on uart_tx / uart_rx
//   rxDataStall                    RX consumer back-pressure
//   uartRxEnable, uartTxEnable     path enables
//   rts_n                          request-to-send, active-low
//   eventReady{Rx,Tx}              1-cycle pulse: path started
//   event{Rx,Tx}Stopped            1-cycle pulse: path fully stopped
//   eventTxTimeout                 1-cycle pulse: TX drain forced to stop
module uart_trx_ctrl #(
  parameter int RX_GUARD_CYCLES = 16,
  parameter int TX_DRAIN_MAX    = 4096
) (
  input  logic ck,
  input  logic arst,
  input  logic uartEnable,
  input  logic taskStartRx,
  input  logic taskStartTx,
  input  logic taskStopRx,
  input  logic taskStopTx,
  input  logic taskStopTrx,
  input  logic txBusy,
  input  logic rxBusy,
  input  logic rxDataStall,
  output logic uartRxEnable,
  output logic uartTxEnable,
  output logic rts_n,
  output logic eventReadyRx,
  output logic eventReadyTx,
  output logic eventRxStopped,
  output logic eventTxStopped,
  output logic eventTxTimeout
);
  localparam int RXW = $clog2(RX_GUARD_CYCLES + 1);
  localparam int TXW = $clog2(TX_DRAIN_MAX + 1);
  localparam logic [1:0] TX_IDLE = 2'd0, TX_ACTIVE = 2'd1, TX_DRAIN = 2'd2;
  localparam logic [1:0] RX_IDLE = 2'd0, RX_ACTIVE = 2'd1, RX_GUARD = 2'd2;
  logic [1:0] r_tx_st, r_rx_st, w_tx_nxt, w_rx_nxt;
  logic [TXW-1:0] r_tx_cnt;
  logic [RXW-1:0] r_rx_cnt;
  logic w_stop_tx, w_stop_rx, w_tx_tmo, w_rx_done;
  assign w_stop_tx = taskStopTx | taskStopTrx;
  assign w_stop_rx = taskStopRx | taskStopTrx;
  assign w_tx_tmo  = (r_tx_st == TX_DRAIN) && txBusy && (r_tx_cnt == TXW'(TX_DRAIN_MAX - 1));
  assign w_rx_done = r_rx_cnt == RXW'(RX_GUARD_CYCLES - 1);
  // a stop pulse coinciding with a start from idle cancels it; uartEnable low overrides everything
  always_comb begin
    w_tx_nxt = !uartEnable              ? TX_IDLE :
               (r_tx_st == TX_IDLE)     ? ((taskStartTx && !w_stop_tx) ? TX_ACTIVE : TX_IDLE) :
               (r_tx_st == TX_ACTIVE)   ? (w_stop_tx ? (txBusy ? TX_DRAIN : TX_IDLE) : TX_ACTIVE) :
               (r_tx_st == TX_DRAIN)    ? ((!txBusy || w_tx_tmo) ? TX_IDLE : TX_DRAIN) :
                                          TX_IDLE;
    w_rx_nxt = !uartEnable              ? RX_IDLE :
               (r_rx_st == RX_IDLE)     ? ((taskStartRx && !w_stop_rx) ? RX_ACTIVE : RX_IDLE) :
               (r_rx_st == RX_ACTIVE)   ? (w_stop_rx ? RX_GUARD : RX_ACTIVE) :
               (r_rx_st == RX_GUARD)    ? ((w_rx_done && !rxBusy) ? RX_IDLE : RX_GUARD) :
                                          RX_IDLE;
  end
  // outputs are registered from the next-state decode so they line up with the state change
  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      r_tx_st        <= TX_IDLE;
      r_rx_st        <= RX_IDLE;
      r_tx_cnt       <= '0;
      r_rx_cnt       <= '0;
      uartTxEnable   <= 1'b0;
      uartRxEnable   <= 1'b0;
      rts_n          <= 1'b1;
      eventReadyTx   <= 1'b0;
      eventReadyRx   <= 1'b0;
      eventTxStopped <= 1'b0;
      eventRxStopped <= 1'b0;
      eventTxTimeout <= 1'b0;
    end else begin
      r_tx_st        <= w_tx_nxt;
      r_rx_st        <= w_rx_nxt;
      r_tx_cnt       <= (r_tx_st == TX_DRAIN && w_tx_nxt == TX_DRAIN) ? r_tx_cnt + TXW'(1) : '0;
      // guard counter parks at its terminal value while rxBusy holds the path open
      r_rx_cnt       <= (r_rx_st == RX_GUARD && w_rx_nxt == RX_GUARD) ?
                        (w_rx_done ? r_rx_cnt : r_rx_cnt + RXW'(1)) : '0;
      uartTxEnable   <= w_tx_nxt != TX_IDLE;
      uartRxEnable   <= w_rx_nxt != RX_IDLE;
      rts_n          <= !(w_rx_nxt == RX_ACTIVE && !rxDataStall);
      eventReadyTx   <= (r_tx_st == TX_IDLE) && (w_tx_nxt == TX_ACTIVE);
      eventReadyRx   <= (r_rx_st == RX_IDLE) && (w_rx_nxt == RX_ACTIVE);
      eventTxStopped <= (r_tx_st != TX_IDLE) && (w_tx_nxt == TX_IDLE);
      eventRxStopped <= (r_rx_st != RX_IDLE) && (w_rx_nxt == RX_IDLE);
      eventTxTimeout <= uartEnable && w_tx_tmo;
    end
  end
endmodule
